// File: rtl/pc_redirect_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pc_redirect_sequencer_pkg
// Shared definitions for the fetch-redirect sequencer:
//   bj_code_e   - 2-bit decision code from the EX-stage branch/jump unit
//   pcs_state_e - sequencer state encoding (BOOT / RUN / FLUSH)
//   is_misaligned() - true when a redirect target is not word aligned
// ---------------------------------------------------------------------------
package pc_redirect_sequencer_pkg;

    typedef enum logic [1:0] {
        BJ_SEQUENCE  = 2'b00,
        BJ_BRANCH    = 2'b01,
        BJ_JUMP      = 2'b10,
        BJ_NOTBRANCH = 2'b11
    } bj_code_e;

    typedef enum logic [1:0] {
        PCS_BOOT  = 2'b00,
        PCS_RUN   = 2'b01,
        PCS_FLUSH = 2'b10
    } pcs_state_e;

    localparam int FLUSH_CNT_WIDTH = 3;

    // A fetch address must have its two low bits clear.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return |low_bits;
    endfunction

endpackage

// File: rtl/pc_redirect_sequencer.sv
// ---------------------------------------------------------------------------
// pc_redirect_sequencer
// Owns the program counter. Advances it by 4 on each accepted fetch, and on a
// taken branch/jump from EX loads the (word-aligned) target and squashes the
// wrong-path IF/ID and ID/EX registers for FLUSH_CYCLES cycles.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   synchronous reset, active low
//   ex_valid       in   EX stage holds a real instruction
//   branch_Or_Jump in   decision code (sequence / branch / jump / not-branch)
//   branch_target  in   target used on a branch
//   jump_target    in   target used on a jump
//   stall          in   hazard stall; freezes sequential advance
//   if_ready       in   instruction memory accepts pc this cycle
//   pc             out  fetch address (registered)
//   fetch_valid    out  pc is a valid fetch request
//   flush_if_id    out  squash IF/ID
//   flush_id_ex    out  squash ID/EX
//   misalign_err   out  one-cycle pulse after a misaligned taken redirect
//   redirect_cnt   out  taken redirects since reset (wraps)
// ---------------------------------------------------------------------------
module pc_redirect_sequencer
    import pc_redirect_sequencer_pkg::*;
#(
    parameter int                     PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC     = 32'h0000_0000,
    parameter int                     FLUSH_CYCLES = 2,
    parameter int                     CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    input  logic [1:0]           branch_Or_Jump,
    input  logic [PC_WIDTH-1:0]  branch_target,
    input  logic [PC_WIDTH-1:0]  jump_target,
    input  logic                 stall,
    input  logic                 if_ready,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 fetch_valid,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 misalign_err,
    output logic [CNT_WIDTH-1:0] redirect_cnt
);

    localparam logic [FLUSH_CNT_WIDTH-1:0] FLUSH_LOAD = FLUSH_CNT_WIDTH'(FLUSH_CYCLES);
    localparam logic [PC_WIDTH-1:0]        PC_STEP    = PC_WIDTH'(32'd4);

    pcs_state_e                  state_r;
    pcs_state_e                  state_nxt_s;
    logic [FLUSH_CNT_WIDTH-1:0]  flush_cnt_r;
    logic [FLUSH_CNT_WIDTH-1:0]  flush_cnt_nxt_s;

    logic [PC_WIDTH-1:0]         pc_r;
    logic [PC_WIDTH-1:0]         pc_nxt_s;
    logic                        fetch_valid_r;
    logic                        fetch_valid_nxt_s;
    logic                        flush_r;
    logic                        flush_nxt_s;
    logic                        misalign_r;
    logic                        misalign_nxt_s;
    logic [CNT_WIDTH-1:0]        redirect_cnt_r;
    logic [CNT_WIDTH-1:0]        redirect_cnt_nxt_s;

    logic                        is_redirect_code_s;
    logic                        taken_s;
    logic                        advance_s;
    logic [PC_WIDTH-1:0]         target_s;

    // Decode the EX decision: select target and qualify the redirect.
    always_comb begin
        is_redirect_code_s = 1'b0;
        target_s           = branch_target;
        case (bj_code_e'(branch_Or_Jump))
            BJ_BRANCH: begin
                is_redirect_code_s = 1'b1;
                target_s           = branch_target;
            end
            BJ_JUMP: begin
                is_redirect_code_s = 1'b1;
                target_s           = jump_target;
            end
            default: begin
                is_redirect_code_s = 1'b0;
                target_s           = branch_target;
            end
        endcase
        // Only RUN listens to EX; decisions seen in FLUSH are wrong-path.
        taken_s   = ex_valid && (state_r == PCS_RUN) && is_redirect_code_s;
        advance_s = if_ready && !stall;
    end

    // State register and flush counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= PCS_BOOT;
            flush_cnt_r <= 3'd0;
        end else begin
            state_r     <= state_nxt_s;
            flush_cnt_r <= flush_cnt_nxt_s;
        end
    end

    // Next-state logic; FLUSH length is purely time-based.
    always_comb begin
        state_nxt_s     = state_r;
        flush_cnt_nxt_s = flush_cnt_r;
        case (state_r)
            PCS_BOOT: begin
                state_nxt_s     = PCS_RUN;
                flush_cnt_nxt_s = 3'd0;
            end
            PCS_RUN: begin
                if (taken_s) begin
                    state_nxt_s     = PCS_FLUSH;
                    flush_cnt_nxt_s = FLUSH_LOAD;
                end else begin
                    state_nxt_s     = PCS_RUN;
                    flush_cnt_nxt_s = 3'd0;
                end
            end
            PCS_FLUSH: begin
                // A count of 0 here is unreachable; treat it as done.
                if (flush_cnt_r <= 3'd1) begin
                    state_nxt_s     = PCS_RUN;
                    flush_cnt_nxt_s = 3'd0;
                end else begin
                    state_nxt_s     = PCS_FLUSH;
                    flush_cnt_nxt_s = flush_cnt_r - 3'd1;
                end
            end
            default: begin
                state_nxt_s     = PCS_BOOT;
                flush_cnt_nxt_s = 3'd0;
            end
        endcase
    end

    // Output-next logic: pc update, flush/valid decode, error and counter.
    always_comb begin
        pc_nxt_s = pc_r;
        case (state_r)
            PCS_BOOT: begin
                pc_nxt_s = pc_r;
            end
            PCS_RUN: begin
                // Redirect beats stall and any pending sequential advance.
                if (taken_s) begin
                    pc_nxt_s = {target_s[PC_WIDTH-1:2], 2'b00};
                end else if (advance_s) begin
                    pc_nxt_s = pc_r + PC_STEP;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            PCS_FLUSH: begin
                if (advance_s) begin
                    pc_nxt_s = pc_r + PC_STEP;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            default: begin
                pc_nxt_s = RESET_PC;
            end
        endcase

        fetch_valid_nxt_s  = (state_nxt_s != PCS_BOOT);
        flush_nxt_s        = (state_nxt_s == PCS_FLUSH);
        misalign_nxt_s     = taken_s && is_misaligned(target_s[1:0]);
        redirect_cnt_nxt_s = redirect_cnt_r;
        if (taken_s) begin
            redirect_cnt_nxt_s = redirect_cnt_r + CNT_WIDTH'(1'b1);
        end else begin
            redirect_cnt_nxt_s = redirect_cnt_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r           <= RESET_PC;
            fetch_valid_r  <= 1'b0;
            flush_r        <= 1'b0;
            misalign_r     <= 1'b0;
            redirect_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            pc_r           <= pc_nxt_s;
            fetch_valid_r  <= fetch_valid_nxt_s;
            flush_r        <= flush_nxt_s;
            misalign_r     <= misalign_nxt_s;
            redirect_cnt_r <= redirect_cnt_nxt_s;
        end
    end

    assign pc           = pc_r;
    assign fetch_valid  = fetch_valid_r;
    assign flush_if_id  = flush_r;
    assign flush_id_ex  = flush_r;
    assign misalign_err = misalign_r;
    assign redirect_cnt = redirect_cnt_r;

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_sequencer
// Directed scenarios followed by randomized traffic, all compared against a
// cycle-level reference model of the sequencer's observable behaviour.
// A narrow redirect counter is used so that counter wrap is exercised.
// ---------------------------------------------------------------------------
module tb_pc_redirect_sequencer;

    localparam int          PCW      = 32;
    localparam int          CW       = 4;
    localparam int          FC       = 2;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    localparam logic [1:0]  C_SEQ = 2'b00;
    localparam logic [1:0]  C_BR  = 2'b01;
    localparam logic [1:0]  C_JMP = 2'b10;
    localparam logic [1:0]  C_NB  = 2'b11;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ex_valid;
    logic [1:0]     branch_Or_Jump;
    logic [PCW-1:0] branch_target;
    logic [PCW-1:0] jump_target;
    logic           stall;
    logic           if_ready;
    logic [PCW-1:0] pc;
    logic           fetch_valid;
    logic           flush_if_id;
    logic           flush_id_ex;
    logic           misalign_err;
    logic [CW-1:0]  redirect_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [31:0]    m_pc;
    bit             m_boot;
    int             m_flush_left;
    logic [CW-1:0]  m_cnt;
    bit             m_mis;

    always #5 clk = ~clk;

    pc_redirect_sequencer #(
        .PC_WIDTH     (PCW),
        .RESET_PC     (RST_PC),
        .FLUSH_CYCLES (FC),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .branch_Or_Jump (branch_Or_Jump),
        .branch_target  (branch_target),
        .jump_target    (jump_target),
        .stall          (stall),
        .if_ready       (if_ready),
        .pc             (pc),
        .fetch_valid    (fetch_valid),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .misalign_err   (misalign_err),
        .redirect_cnt   (redirect_cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs applied for that edge.
    task automatic model_edge(input bit rn, input bit ev, input logic [1:0] code,
                              input logic [31:0] bt, input logic [31:0] jt,
                              input bit st, input bit rdy);
        bit          taken;
        logic [31:0] tgt;
        if (!rn) begin
            m_pc         = RST_PC;
            m_boot       = 1'b1;
            m_flush_left = 0;
            m_cnt        = '0;
            m_mis        = 1'b0;
        end else begin
            taken = ev && !m_boot && (m_flush_left == 0) && (code == C_BR || code == C_JMP);
            tgt   = (code == C_JMP) ? jt : bt;
            m_mis = taken && (tgt % 4 != 0);
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (taken) begin
                m_pc         = tgt - (tgt % 4);
                m_flush_left = FC;
                m_cnt        = m_cnt + 1'b1;
            end else begin
                if (rdy && !st) m_pc = m_pc + 32'd4;
                if (m_flush_left > 0) m_flush_left--;
            end
        end
    endtask

    task automatic compare_all();
        check_val("pc",           64'(pc),           64'(m_pc));
        check_val("fetch_valid",  64'(fetch_valid),  64'(!m_boot));
        check_val("flush_if_id",  64'(flush_if_id),  64'(m_flush_left > 0));
        check_val("flush_id_ex",  64'(flush_id_ex),  64'(m_flush_left > 0));
        check_val("misalign_err", 64'(misalign_err), 64'(m_mis));
        check_val("redirect_cnt", 64'(redirect_cnt), 64'(m_cnt));
    endtask

    task automatic step(input bit rn, input bit ev, input logic [1:0] code,
                        input logic [31:0] bt, input logic [31:0] jt,
                        input bit st, input bit rdy);
        @(negedge clk);
        rst_n          = rn;
        ex_valid       = ev;
        branch_Or_Jump = code;
        branch_target  = bt;
        jump_target    = jt;
        stall          = st;
        if_ready       = rdy;
        @(posedge clk);
        model_edge(rn, ev, code, bt, jt, st, rdy);
        #1;
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; branch_Or_Jump = C_SEQ;
        branch_target = '0; jump_target = '0; stall = 1'b0; if_ready = 1'b0;

        // Reset state.
        step(1'b0, 1'b0, C_SEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, C_SEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        check_val("rst_fv",  64'(fetch_valid), 64'd0);
        check_val("rst_pc",  64'(pc),          64'd0);

        // Boot bubble then sequential fetch 0,4,8.
        step(1'b1, 1'b0, C_SEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        check_val("boot_pc0", 64'(pc), 64'h0);
        check_val("boot_fv",  64'(fetch_valid), 64'd1);
        step(1'b1, 1'b0, C_SEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        check_val("seq_pc4", 64'(pc), 64'h4);
        step(1'b1, 1'b0, C_SEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        check_val("seq_pc8", 64'(pc), 64'h8);

        // Taken branch to 0x100, two flush cycles.
        step(1'b1, 1'b1, C_BR, 32'h100, 32'h0, 1'b0, 1'b1);
        check_val("br_pc",    64'(pc),          64'h100);
        check_val("br_flush", 64'(flush_if_id), 64'd1);
        check_val("br_cnt",   64'(redirect_cnt), 64'd1);
        step(1'b1, 1'b0, C_SEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        check_val("br_flush2", 64'(flush_id_ex), 64'd1);
        step(1'b1, 1'b0, C_SEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        check_val("br_flush_end", 64'(flush_id_ex), 64'd0);

        // Not-taken branch keeps sequencing.
        step(1'b1, 1'b1, C_NB, 32'h500, 32'h0, 1'b0, 1'b1);
        check_val("nb_flush", 64'(flush_if_id), 64'd0);

        // Misaligned jump, then a jump during flush is ignored.
        step(1'b1, 1'b1, C_JMP, 32'h0, 32'h203, 1'b0, 1'b1);
        check_val("jmp_pc",  64'(pc),           64'h200);
        check_val("jmp_mis", 64'(misalign_err), 64'd1);
        step(1'b1, 1'b1, C_JMP, 32'h0, 32'h400, 1'b0, 1'b1);
        check_val("wrongpath_cnt", 64'(redirect_cnt), 64'd2);
        check_val("mis_pulse",     64'(misalign_err), 64'd0);
        step(1'b1, 1'b0, C_SEQ, 32'h0, 32'h0, 1'b0, 1'b1);

        // Stall and not-ready hold; redirect under stall still loads.
        step(1'b1, 1'b0, C_SEQ, 32'h0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 1'b0, C_SEQ, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, C_BR, 32'h0000_0800, 32'h0, 1'b1, 1'b0);
        check_val("stall_redirect", 64'(pc), 64'h800);
        step(1'b1, 1'b0, C_SEQ, 32'h0, 32'h0, 1'b1, 1'b1);

        // Reset during the second flush cycle.
        step(1'b1, 1'b0, C_SEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b1, C_JMP, 32'h0, 32'h0000_0A00, 1'b0, 1'b1);
        step(1'b1, 1'b0, C_SEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, C_SEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        check_val("midflush_rst_flush", 64'(flush_if_id), 64'd0);
        check_val("midflush_rst_pc",    64'(pc),          64'(RST_PC));
        step(1'b1, 1'b0, C_SEQ, 32'h0, 32'h0, 1'b0, 1'b1);

        // PC wrap past the top of the address space.
        step(1'b1, 1'b1, C_JMP, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b1);
        step(1'b1, 1'b0, C_SEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        check_val("wrap_pc", 64'(pc), 64'h0);

        // Randomized traffic; the narrow counter wraps several times.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] bt;
            logic [31:0] jt;
            bt = $urandom;
            jt = $urandom;
            if ($urandom_range(0, 1) == 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 0) jt[1:0] = 2'b00;
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 2) != 0),
                 2'($urandom_range(0, 3)),
                 bt, jt,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
